// File: rtl/codec_pulse_sync.sv
// Resynchronizes an asynchronous event level into the iclk domain and emits
// one-cycle pulses on the selected edge, masked for a while after reset.
module codec_pulse_sync #(
   parameter int unsigned pLENGTH = 3,
   parameter int unsigned pEDGE   = 0
) (
   input  logic iclk,
   input  logic ireset,
   input  logic iclkena,
   input  logic sin,
   output logic sout,
   output logic olevel,
   output logic obusy
);

   localparam int unsigned CNT_W = $clog2(pLENGTH + 2);

   (* ASYNC_REG = "TRUE" *) logic [pLENGTH-1:0] sync;
   logic             prev;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             edge_c;

   // Metastability-hardening chain; only sync[0] samples the async input.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         sync <= '0;
      end else if (iclkena) begin
         sync <= {sync[pLENGTH-2:0], sin};
      end
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         prev <= 1'b0;
      end else if (iclkena) begin
         prev <= sync[pLENGTH-1];
      end
   end

   // busy mirrors (cnt != 0) but is kept as its own flop so obusy is registered.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         cnt  <= CNT_W'(pLENGTH + 1);
         busy <= 1'b1;
      end else if (iclkena) begin
         if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         busy <= (cnt > CNT_W'(1));
      end
   end

   always_comb begin
      edge_c = 1'b0;
      if (pEDGE == 0) begin
         edge_c = sync[pLENGTH-1] & ~prev;
      end else if (pEDGE == 1) begin
         edge_c = ~sync[pLENGTH-1] & prev;
      end else begin
         edge_c = sync[pLENGTH-1] ^ prev;
      end
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         sout <= 1'b0;
      end else if (iclkena) begin
         sout <= edge_c & ~busy;
      end
   end

   assign olevel = sync[pLENGTH-1];
   assign obusy  = busy;

endmodule

// File: tb/tb_codec_pulse_sync.sv
// Directed and randomized checks of codec_pulse_sync across several
// chain depths and edge modes sharing one stimulus.
module tb_codec_pulse_sync;

   logic iclk;
   logic ireset;
   logic iclkena;
   logic sin;

   logic sout_a, olevel_a, obusy_a;   // L=3 rise
   logic sout_b, olevel_b, obusy_b;   // L=3 both
   logic sout_c, olevel_c, obusy_c;   // L=4 rise
   logic sout_d, olevel_d, obusy_d;   // L=2 fall
   logic sout_e, olevel_e, obusy_e;   // L=5 both

   int total = 0;
   int bad   = 0;

   codec_pulse_sync #(.pLENGTH(3), .pEDGE(0)) dut_a (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .sin(sin),
      .sout(sout_a), .olevel(olevel_a), .obusy(obusy_a));
   codec_pulse_sync #(.pLENGTH(3), .pEDGE(2)) dut_b (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .sin(sin),
      .sout(sout_b), .olevel(olevel_b), .obusy(obusy_b));
   codec_pulse_sync #(.pLENGTH(4), .pEDGE(0)) dut_c (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .sin(sin),
      .sout(sout_c), .olevel(olevel_c), .obusy(obusy_c));
   codec_pulse_sync #(.pLENGTH(2), .pEDGE(1)) dut_d (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .sin(sin),
      .sout(sout_d), .olevel(olevel_d), .obusy(obusy_d));
   codec_pulse_sync #(.pLENGTH(5), .pEDGE(2)) dut_e (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .sin(sin),
      .sout(sout_e), .olevel(olevel_e), .obusy(obusy_e));

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   bit   pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   int   cnt [5];
   int   werr;
   int   rises;
   int   falls;
   logic lvl;
   logic [4:0] sv;
   logic [4:0] pv;

   task automatic tick_sample();
      tick();
      sv = {sout_e, sout_d, sout_c, sout_b, sout_a};
      for (int i = 0; i < 5; i++) begin
         if (sv[i]) cnt[i]++;
         if (sv[i] && pv[i]) werr++;
      end
      pv = sv;
   endtask

   initial begin
      ireset  = 1'b1;
      iclkena = 1'b1;
      sin     = 1'b0;

      // Basic latency and mask timing; last reset edge is edge 0.
      repeat (3) tick();
      chk("rst_sout",   32'(sout_a),   32'd0);
      chk("rst_olevel", 32'(olevel_a), 32'd0);
      chk("rst_obusy",  32'(obusy_a),  32'd1);
      chk("rst_obusy_e", 32'(obusy_e), 32'd1);
      ireset = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         if (n == 10) sin = 1'b1;
         tick();
         chk("t1_olevel_a", 32'(olevel_a), 32'(n >= 12));
         chk("t1_sout_a",   32'(sout_a),   32'(n == 13));
         chk("t1_obusy_a",  32'(obusy_a),  32'(n < 4));
         chk("t1_olevel_c", 32'(olevel_c), 32'(n >= 13));
         chk("t1_sout_c",   32'(sout_c),   32'(n == 14));
         chk("t1_obusy_c",  32'(obusy_c),  32'(n < 5));
         chk("t1_sout_d",   32'(sout_d),   32'd0);
      end

      // sin held high through reset never produces a pulse.
      ireset = 1'b1;
      repeat (2) tick();
      chk("t2_rst_olevel", 32'(olevel_a), 32'd0);
      chk("t2_rst_sout_e", 32'(sout_e),   32'd0);
      chk("t2_rst_obusy",  32'(obusy_a),  32'd1);
      ireset = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         chk("t2_olevel_a", 32'(olevel_a), 32'(n >= 3));
         chk("t2_sout_a",   32'(sout_a),   32'd0);
         chk("t2_obusy_a",  32'(obusy_a),  32'(n < 4));
         chk("t2_sout_b",   32'(sout_b),   32'd0);
         chk("t2_sout_e",   32'(sout_e),   32'd0);
      end

      // Back-to-back events: 0 -> 1,1,0,0,1,1.
      sin = 1'b0;
      repeat (12) tick();
      for (int n = 0; n <= 12; n++) begin
         sin = (n < 6) ? pat[n] : 1'b1;
         tick();
         chk("t3_sout_a", 32'(sout_a), 32'(n == 3 || n == 7));
         chk("t3_sout_b", 32'(sout_b), 32'(n == 3 || n == 5 || n == 7));
         chk("t3_sout_c", 32'(sout_c), 32'(n == 4 || n == 8));
         chk("t3_sout_d", 32'(sout_d), 32'(n == 4));
         chk("t3_sout_e", 32'(sout_e), 32'(n == 5 || n == 7 || n == 9));
      end

      // Clock enable stalls the chain and holds an active pulse.
      sin = 1'b0;
      repeat (12) tick();
      for (int n = 0; n <= 13; n++) begin
         sin     = 1'b1;
         iclkena = !((n >= 1 && n <= 5) || (n >= 9 && n <= 10));
         tick();
         chk("t4_sout_a",   32'(sout_a),   32'(n >= 8 && n <= 10));
         chk("t4_olevel_a", 32'(olevel_a), 32'(n >= 7));
         chk("t4_sout_c",   32'(sout_c),   32'(n == 11));
         chk("t4_olevel_c", 32'(olevel_c), 32'(n >= 8));
      end
      iclkena = 1'b1;

      // Reset one cycle after sin rises kills the in-flight event.
      sin = 1'b0;
      repeat (12) tick();
      sin = 1'b1;
      tick();
      ireset = 1'b1;
      tick();
      chk("t5_rst_olevel_c", 32'(olevel_c), 32'd0);
      chk("t5_rst_sout_c",   32'(sout_c),   32'd0);
      chk("t5_rst_obusy_c",  32'(obusy_c),  32'd1);
      tick();
      ireset = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         tick();
         chk("t5_obusy_c",  32'(obusy_c),  32'(r < 5));
         chk("t5_sout_c",   32'(sout_c),   32'd0);
         chk("t5_olevel_c", 32'(olevel_c), 32'(r >= 4));
      end

      // Reset while a pulse is high clears it on the next edge.
      sin = 1'b0;
      repeat (12) tick();
      sin = 1'b1;
      repeat (4) tick();
      chk("t6_sout_pre", 32'(sout_a), 32'd1);
      ireset = 1'b1;
      tick();
      chk("t6_sout_rst",   32'(sout_a),   32'd0);
      chk("t6_olevel_rst", 32'(olevel_a), 32'd0);
      tick();
      ireset = 1'b0;
      repeat (12) tick();

      // Random level sequence, each level held 2..5 cycles.
      for (int i = 0; i < 5; i++) cnt[i] = 0;
      werr  = 0;
      rises = 0;
      falls = 0;
      pv    = '0;
      lvl   = 1'b1;
      for (int seg = 0; seg < 200; seg++) begin
         lvl = ~lvl;
         sin = lvl;
         if (lvl) rises++;
         else     falls++;
         repeat ($urandom_range(2, 5)) tick_sample();
      end
      repeat (12) tick_sample();
      chk("rnd_cnt_a", 32'(cnt[0]), 32'(rises));
      chk("rnd_cnt_b", 32'(cnt[1]), 32'(rises + falls));
      chk("rnd_cnt_c", 32'(cnt[2]), 32'(rises));
      chk("rnd_cnt_d", 32'(cnt[3]), 32'(falls));
      chk("rnd_cnt_e", 32'(cnt[4]), 32'(rises + falls));
      chk("rnd_width", 32'(werr),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
